// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters,
// with a registered issue stage and a registered response stage.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [3:0]            req0_ctl,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [3:0]            req1_ctl,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_ctl,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero
);
  localparam logic [3:0] ALU_ADD = 4'b0010;
  logic                  s1_valid_q, s1_id_q, last_grant_q;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_b_q;
  logic [3:0]            s1_ctl_q;
  logic                  rsp_valid_q, rsp_id_q, rsp_zero_q;
  logic [31:0]           rsp_result_q;
  logic                  adv_rsp, adv_s1, any_req, winner, grant;
  always_comb begin
    adv_rsp   = !rsp_valid_q || rsp_ready;
    adv_s1    = !s1_valid_q || adv_rsp;
    any_req   = |req_valid;
    // on contention the requester that did not win last time goes first
    winner    = (&req_valid) ? !last_grant_q : req_valid[1];
    grant     = adv_s1 && any_req;
    req_ready = {grant && winner, grant && !winner};
    alu_a     = s1_valid_q ? s1_a_q : '0;
    alu_b     = s1_valid_q ? s1_b_q : '0;
    alu_ctl   = s1_valid_q ? s1_ctl_q : ALU_ADD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_ctl_q     <= ALU_ADD;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      if (adv_rsp) begin
        rsp_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          rsp_id_q     <= s1_id_q;
          rsp_result_q <= alu_result;
          rsp_zero_q   <= alu_zero;
        end
      end
      if (adv_s1) begin
        s1_valid_q <= any_req;
        if (any_req) begin
          s1_id_q      <= winner;
          s1_a_q       <= winner ? req1_a : req0_a;
          s1_b_q       <= winner ? req1_b : req0_b;
          s1_ctl_q     <= winner ? req1_ctl : req0_ctl;
          last_grant_q <= winner;
        end
      end
    end
  end
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench with a behavioural ALU attached to the shared port.
module tb_alu_arbiter;
  localparam logic [3:0] AND = 4'd0, OR = 4'd1, ADD = 4'd2, XOR = 4'd3, SUB = 4'd6, SLT = 4'd7;
  logic        clk = 0, rst = 1;
  logic [1:0]  req_valid = 0, req_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0]  req0_ctl = 0, req1_ctl = 0;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic [3:0]  alu_ctl;
  logic        alu_zero, rsp_valid, rsp_id, rsp_zero;
  logic        rsp_ready = 1;
  int          checks = 0, errors = 0;
  logic [33:0] got_q[$];
  always #5 clk = ~clk;
  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctl(req0_ctl),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctl(req1_ctl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );
  always_comb begin
    alu_result = 32'h0;
    case (alu_ctl)
      AND: alu_result = alu_a & alu_b;
      OR:  alu_result = alu_a | alu_b;
      ADD: alu_result = alu_a + alu_b;
      XOR: alu_result = alu_a ^ alu_b;
      SUB: alu_result = alu_a - alu_b;
      SLT: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = 32'h0;
    endcase
  end
  assign alu_zero = (alu_result == 32'h0);
  always @(negedge clk) if (!rst && rsp_valid && rsp_ready) got_q.push_back({rsp_id, rsp_zero, rsp_result});
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic [3:0]  t_op [8] = '{AND, XOR, SLT, SLT, ADD, SUB, OR, SLT};
  logic [31:0] t_a  [8] = '{32'hF0F0, 32'hFF, 32'd3, 32'd4, 32'hFFFFFFFF, 32'd10, 32'h100, 32'hFFFFFFFF};
  logic [31:0] t_b  [8] = '{32'hFF00, 32'h0F, 32'd4, 32'd3, 32'd1, 32'd3, 32'h1, 32'd0};
  logic [31:0] t_e  [8] = '{32'hF000, 32'hF0, 32'd1, 32'd0, 32'd0, 32'd7, 32'h101, 32'd1};
  initial begin
    int grants, n;
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_zero", rsp_zero, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_ctl", alu_ctl, ADD);
    tick();
    rst = 0;
    req0_a = 9; req0_b = 9; req0_ctl = SUB;
    req1_a = 32'h0F; req1_b = 32'hF0; req1_ctl = OR;
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'b11;
      #1 chk("cont_ready", req_ready, (i % 2) ? 2'b10 : 2'b01);
      tick();
    end
    req_valid = 0;
    tick(); tick();
    chk("cont_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk("cont_rsp", got_q[i], (i % 2) ? {1'b1, 1'b0, 32'hFF} : {1'b0, 1'b1, 32'h0});
    req0_a = 5; req0_b = 7; req0_ctl = ADD;
    req_valid = 2'b01;
    #1 chk("single_ready", req_ready, 2'b01);
    tick();
    req_valid = 0;
    chk("single_alu_a", alu_a, 5);
    chk("single_lat1", rsp_valid, 0);
    tick();
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 0);
    chk("single_result", rsp_result, 12);
    chk("single_zero", rsp_zero, 0);
    tick();
    rsp_ready = 0; req1_ctl = ADD; req1_b = 1; grants = 0; n = 0;
    req_valid = 2'b10;
    for (int c = 0; c < 5; c++) begin
      req1_a = n;
      #1;
      if (req_ready[1]) begin grants++; n++; end
      if (c >= 2) begin
        chk("bp_valid", rsp_valid, 1);
        chk("bp_result", rsp_result, 1);
      end
      tick();
    end
    chk("bp_grants", grants, 2);
    chk("bp_ready", req_ready, 0);
    req_valid = 0;
    got_q.delete();
    rsp_ready = 1;
    tick(); tick(); tick();
    chk("bp_count", got_q.size(), 2);
    for (int i = 0; i < 2 && i < got_q.size(); i++)
      chk("bp_rsp", got_q[i], {1'b1, 1'b0, 32'(i + 1)});
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      req0_ctl = t_op[i]; req0_a = t_a[i]; req0_b = t_b[i];
      req_valid = 2'b01;
      #1 chk("tp_ready", req_ready, 2'b01);
      if (i >= 2) chk("tp_streak", rsp_valid, 1);
      tick();
    end
    req_valid = 0;
    tick(); tick();
    chk("tp_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      chk("tp_rsp", got_q[i], {1'b0, t_e[i] == 0, t_e[i]});
    req0_a = 100; req0_b = 1; req0_ctl = ADD;
    req_valid = 2'b01;
    tick();
    req0_a = 555; req_valid = 0;
    tick();
    chk("capture_result", rsp_result, 101);
    rsp_ready = 0;
    req_valid = 2'b01; req0_a = 1; req0_b = 2;
    tick(); tick();
    req_valid = 0;
    chk("mid_full", rsp_valid, 1);
    rst = 1;
    #1;
    chk("mid_valid", rsp_valid, 0);
    chk("mid_result", rsp_result, 0);
    chk("mid_id_zero", {rsp_id, rsp_zero}, 0);
    chk("mid_ready", req_ready, 0);
    chk("mid_alu", {alu_a, alu_ctl}, {32'h0, ADD});
    tick();
    rst = 0; rsp_ready = 1;
    tick();
    chk("mid_no_rsp", rsp_valid, 0);
    req_valid = 2'b11;
    #1 chk("mid_first_win", req_ready, 2'b01);
    tick();
    req_valid = 0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between two requesters: requester 0 is the execute stage and requester 1 is the address/branch-compare path. The block arbitrates round-robin, registers the winning operands, drives the shared ALU, and returns the registered result with the requester ID. It is a 2-stage pipeline (issue, response) with valid/ready handshakes on every channel and full throughput of one operation per cycle.

## Interface
- `DATA_WIDTH`, 32, operand and result width (matches `alu`)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  2  per-requester request valid (bit i = requester i)
- `req_ready`  out  2  per-requester accept; a handshake completes when `req_valid[i] && req_ready[i]`
- `req0_a`, `req0_b`  in  DATA_WIDTH each  requester 0 operands
- `req0_ctl`  in  4  requester 0 op code (`alu.vh` encodings)
- `req1_a`, `req1_b`  in  DATA_WIDTH each  requester 1 operands
- `req1_ctl`  in  4  requester 1 op code
- `alu_a`, `alu_b`  out  DATA_WIDTH  to the shared ALU `A`/`B`
- `alu_ctl`  out  4  to the shared ALU `ALUCtl`
- `alu_result`  in  32  from the ALU `Result`
- `alu_zero`  in  1  from the ALU `Zero`
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  1  requester that owns the response
- `rsp_result`  out  32  registered ALU result
- `rsp_zero`  out  1  registered ALU zero flag

## Operation
- Issue stage: registers `s1_valid`, `s1_id`, `s1_a`, `s1_b`, `s1_ctl`. `alu_a`/`alu_b`/`alu_ctl` are driven directly from the s1 registers. When `s1_valid`=0 they are driven as 0 with `ALU_ADD`.
- Response stage: registers `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_zero`, captured from `s1_id`, `alu_result` and `alu_zero`.
- `adv_rsp = !rsp_valid || rsp_ready`. `adv_s1 = !s1_valid || adv_rsp`.
- When `adv_rsp` is high, the response stage loads `s1_valid` (and its data when valid). A consumed response with an empty s1 clears `rsp_valid`.
- Arbitration happens only when `adv_s1`=1:
  - If exactly one `req_valid` bit is set, that requester wins.
  - If both are set, the winner is the requester not recorded in `last_grant`.
  - `last_grant` updates to the winner on every grant.
- `req_ready[i]` = `adv_s1 && winner==i`. It is combinational from `req_valid`, `last_grant`, `s1_valid`, `rsp_valid` and `rsp_ready`, and is never asserted for a non-winner.
- No request is dropped or duplicated. Responses leave in grant order.
- Operands are captured at the grant edge, so requesters may change them after the handshake.

## Timing
- Reset (async assert, synchronous deassert by the system): `s1_valid`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_zero`=0, `last_grant`=1 (requester 0 wins the first contention), and `alu_*` = 0/`ALU_ADD`.
- Latency: a request granted at edge k produces `rsp_valid`=1 after edge k+1, two cycles after it was presented.
- Throughput: one grant per cycle while `rsp_ready`=1.
- Backpressure:
  - Holding `rsp_ready`=0 keeps `rsp_*` stable.
  - s1 fills at most one more entry, after which `req_ready`=0.
  - The pipeline holds at most 2 operations.
- Simultaneous events in one cycle: a response consumed, s1 moving to the response stage, and a new grant loading s1 is legal and required.
- Reset mid-operation: in-flight operations are discarded, with no response and no `req_ready` after reset.

## Test plan
- Single request: req0 ADD a=5, b=7 at cycle 0, `rsp_ready`=1 → `req_ready`=2'b01 in cycle 0; `rsp_valid`=1, `rsp_id`=0, `rsp_result`=12, `rsp_zero`=0 in cycle 2.
- Contention: both requesters hold valid for 4 cycles (req0 SUB 9-9, req1 OR 0x0F|0xF0) → grants alternate 0,1,0,1. Responses: `rsp_result`=0 with `rsp_zero`=1 for id 0, and 0xFF with `rsp_zero`=0 for id 1.
- Backpressure: continuous req1 ADD i+1 with `rsp_ready`=0 for 5 cycles → exactly 2 grants, `rsp_*` stable, `req_ready`=0 afterwards. After releasing `rsp_ready`, responses arrive in order with no loss.
- Full-throughput mixed ops: 8 back-to-back req0 ops (AND, XOR, SLT 3<4 → 1, SLT 4<3 → 0, …) → 8 consecutive `rsp_valid` cycles with matching results.
- Reset mid-flight: assert `rst` with both stages full → `rsp_valid`, `req_ready` and all `rsp_*` go to 0 immediately; the next contention is won by req0.
- Operand change after handshake: alter `req0_a` the cycle after grant → the response uses the captured value.
